// File: rtl/kbd_cmd_pkg.sv
// Shared mode encoding and PS/2 set-2 scan-code constants for the keyboard command FSM.
package kbd_cmd_pkg;

    typedef enum logic [2:0] {
        ModeInit  = 3'd0,
        ModeIsa   = 3'd1,
        ModeAlu   = 3'd2,
        ModeBench = 3'd3,
        ModeRun   = 3'd4
    } mode_t;

    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_BKSP  = 8'h66;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_I     = 8'h43;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_B     = 8'h32;
    localparam logic [7:0] KEY_R     = 8'h2D;
    localparam logic [7:0] PFX_BREAK = 8'hF0;
    localparam logic [7:0] PFX_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_make_filter.sv
// Passes only plain make codes; swallows F0 xx, E0 xx and E0 F0 xx sequences.
module ps2_make_filter
    import kbd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       make_valid,
    output logic [7:0] make_code
);

    logic drop_q;
    logic ext_q;

    // Combinational pass-through so a key reaches the line buffer at the edge it arrives.
    assign make_valid = key_valid && !drop_q && !ext_q &&
                        (key_code != PFX_BREAK) && (key_code != PFX_EXT);
    assign make_code  = key_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 1'b0;
            ext_q  <= 1'b0;
        end else if (key_valid) begin
            if (drop_q) begin
                drop_q <= 1'b0;
                ext_q  <= 1'b0;
            end else if (key_code == PFX_BREAK) begin
                drop_q <= 1'b1;
            end else if (key_code == PFX_EXT) begin
                ext_q <= 1'b1;
            end else if (ext_q) begin
                ext_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/kbd_cmd_fsm.sv
// Keyboard mode controller: line buffer plus INIT/ISA/ALU/BENCH/RUN mode FSM.
module kbd_cmd_fsm
    import kbd_cmd_pkg::*;
#(
    parameter int unsigned LINE_DEPTH = 8,
    parameter int unsigned LEN_W      = $clog2(LINE_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [7:0]              key_code,
    input  logic                    run_done,
    output logic [2:0]              mode,
    output logic [8*LINE_DEPTH-1:0] line_data,
    output logic [LEN_W-1:0]        line_len,
    output logic                    line_go,
    output logic                    cpu_start,
    output logic                    overflow
);

    mode_t state_q;

    logic       kv;
    logic [7:0] kc;

    logic [8*LINE_DEPTH-1:0] base_data;
    logic [8*LINE_DEPTH-1:0] push_data;
    logic [8*LINE_DEPTH-1:0] pop_data;
    logic [LEN_W-1:0]        base_len;
    logic                    base_ovf;
    logic                    base_single;
    logic                    base_empty;

    ps2_make_filter u_filter (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .make_valid (kv),
        .make_code  (kc)
    );

    assign mode = state_q;

    // The cycle after a submission the buffer starts out empty; any key in it lands on top.
    always_comb begin
        base_data   = line_go ? '0 : line_data;
        base_len    = line_go ? '0 : line_len;
        base_ovf    = line_go ? 1'b0 : overflow;
        push_data   = {base_data[8*LINE_DEPTH-9:0], kc};
        pop_data    = {8'h00, base_data[8*LINE_DEPTH-1:8]};
        base_single = (base_len == LEN_W'(1));
        base_empty  = (base_len == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ModeInit;
            line_data <= '0;
            line_len  <= '0;
            line_go   <= 1'b0;
            cpu_start <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            line_go   <= 1'b0;
            cpu_start <= 1'b0;
            line_data <= base_data;
            line_len  <= base_len;
            overflow  <= base_ovf;

            if (kv && kc == KEY_ESC) begin
                state_q   <= ModeInit;
                line_data <= '0;
                line_len  <= '0;
                overflow  <= 1'b0;
            end else if (state_q == ModeRun) begin
                if (run_done) begin
                    state_q <= ModeInit;
                end
            end else if (kv) begin
                if (kc == KEY_ENTER) begin
                    case (state_q)
                        ModeInit: begin
                            line_data <= '0;
                            line_len  <= '0;
                            overflow  <= 1'b0;
                            if (base_single) begin
                                case (base_data[7:0])
                                    KEY_I:   state_q <= ModeIsa;
                                    KEY_A:   state_q <= ModeAlu;
                                    KEY_B:   state_q <= ModeBench;
                                    default: state_q <= ModeInit;
                                endcase
                            end
                        end
                        ModeIsa: begin
                            if (base_single && base_data[7:0] == KEY_R) begin
                                state_q   <= ModeRun;
                                cpu_start <= 1'b1;
                                line_data <= '0;
                                line_len  <= '0;
                                overflow  <= 1'b0;
                            end else if (!base_empty) begin
                                line_go <= 1'b1;
                            end
                        end
                        default: begin
                            if (!base_empty) begin
                                line_go <= 1'b1;
                            end
                        end
                    endcase
                end else if (kc == KEY_BKSP) begin
                    if (!base_empty) begin
                        line_data <= pop_data;
                        line_len  <= base_len - LEN_W'(1);
                    end
                end else if (base_len < LEN_W'(LINE_DEPTH)) begin
                    line_data <= push_data;
                    line_len  <= base_len + LEN_W'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/kbd_cmd_fsm.md
# kbd_cmd_fsm

Keyboard-driven mode controller for the lab CPU system. It consumes a PS/2 set-2 scan-code byte stream and filters out break and extended codes. It collects typed characters into a parametrised line buffer and, on Enter, either switches between INIT/ISA/ALU/BENCH/RUN modes or hands the completed line to the active mode's consumer with a one-cycle go pulse. It sits between the PS/2 receiver and the instruction-memory writer, ALU interface, benchmark unit and CPU start/done handshake.

## Interface
- LINE_DEPTH, 8: maximum characters held in the line buffer (≥2).
- LEN_W, $clog2(LINE_DEPTH+1): width of line_len.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- key_valid  in  1  one-cycle strobe, key_code valid.
- key_code  in  8  raw PS/2 set-2 byte (make, 0xF0 break prefix, 0xE0 extended prefix).
- run_done  in  1  CPU finished program (level or pulse).
- mode  out  3  current state: INIT=0, ISA=1, ALU=2, BENCH=3, RUN=4.
- line_data  out  8*LINE_DEPTH  buffered make codes; [7:0] newest, unused bytes zero.
- line_len  out  LEN_W  characters currently buffered.
- line_go  out  1  one-cycle pulse: line submitted in ISA/ALU/BENCH.
- cpu_start  out  1  one-cycle pulse on entry to RUN.
- overflow  out  1  sticky: a character was dropped because the buffer was full.

## Operation
- Filter: 0xF0 arms a drop-next flag, and the following byte is discarded. 0xE0 arms an extended flag, and the next non-0xF0 byte is discarded, so E0 xx and E0 F0 xx both vanish. Only surviving make codes are "keys".
- Special keys: 0x5A Enter, 0x66 Backspace, 0x76 Escape. All other keys are characters.
- Character: if line_len<LINE_DEPTH, shift line_data left 8 bits, insert the code at [7:0], and increment line_len. Otherwise drop it and set overflow.
- Backspace: shift right 8 bits, zero-fill the top byte, and decrement line_len. No-op when line_len=0.
- Escape: in any state, go to INIT and clear the line and overflow.
- Enter in INIT: if line_len=1, then [7:0]=0x43 ('i') goes to ISA, 0x1C ('a') goes to ALU, and 0x32 ('b') goes to BENCH. Any other line stays in INIT. The line is always cleared.
- Enter in ISA: a single 0x2D ('r') goes to RUN with no line_go. A non-empty line pulses line_go. Empty Enter does nothing. The line is always cleared after the action.
- Enter in ALU/BENCH: a non-empty line pulses line_go, and the state is unchanged.
- RUN: cpu_start pulses in the first RUN cycle. All keys except Escape are ignored and the filter keeps tracking. run_done goes to INIT.
- Clearing the line zeroes line_data and line_len and clears overflow.

## Timing
- Reset: mode=INIT, line_data=0, line_len=0, line_go=0, cpu_start=0, overflow=0, filter flags cleared. Reset mid-line or mid-RUN discards everything.
- All outputs are registered. A key accepted at edge N is visible in line_data/line_len/mode after edge N.
- Submission on Enter at edge N:
  - line_go=1 for exactly cycle N..N+1.
  - line_data/line_len hold the submitted line during that cycle.
  - The clear happens at edge N+1.
- A key arriving in the line_go cycle is applied after the clear: at edge N+1 the buffer holds just that key.
- cpu_start is high the cycle after the transition edge into RUN.
- RUN with run_done and an Escape key in the same cycle: go to INIT once, with no double action.
- run_done asserted while not in RUN is ignored.
- Throughput: one key per cycle. No backpressure.

## Structure
- Package kbd_cmd_pkg: mode_t state encoding, scan-code constants (KEY_ENTER, KEY_BKSP, KEY_ESC, KEY_I, KEY_A, KEY_B, KEY_R, PFX_BREAK, PFX_EXT).
- Sub-module ps2_make_filter: raw byte plus strobe in, make code plus strobe out, holding the F0/E0 flags. The top holds the mode FSM and line buffer.

## Test plan
- Reset, then 43 F0 43 5A: mode=1, line_len=0. No line_go.
- In ISA with LINE_DEPTH=8: 16 F0 16 1E F0 1E 5A → line_go for one cycle with line_len=2 and line_data[15:0]=0x161E. Next cycle line_len=0.
- In ALU: nine 0x1C keys → line_len=8, overflow=1. Then 66 → line_len=7. Then 5A → line_go, and overflow clears after the submit.
- In ISA: E0 75 E0 F0 75 66 2D 5A → arrow and empty backspace have no effect, mode=4, cpu_start pulses once. run_done → mode=0.
- In RUN, Escape and run_done in the same cycle → mode=0 with a single transition. In BENCH, rst asserted mid-line → all outputs return to reset values.
